instruction_encoder_loader: RTL and testbench

//   Inverse of the field decoder: packs instruction fields into 32-bit words of the

---
 rtl/instruction_encoder_loader_if.sv | 44 ++++
 rtl/instruction_encoder_loader.sv | 134 +++++++++++++
 tb/tb_instruction_encoder_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_loader_if.sv
// instruction_encoder_loader_if
//   Groups the loader-side field stream, the session control and the
//   instruction-memory write port of instruction_encoder_loader.
//   master : boot/test loader view (drives start, base_addr, field beats;
//            observes in_ready, the write port and session status)
//   slave  : encoder/loader view (the reverse)
//   Parameter ADDR_W : instruction-memory word-address width.
interface instruction_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cond;
  logic [4:0]        in_opcode;
  logic [3:0]        in_Rn;
  logic [3:0]        in_Rm;
  logic [3:0]        in_Rd;
  logic [10:0]       in_imm;
  logic [1:0]        in_shift_type;
  logic [4:0]        in_shift_amt;
  logic              in_use_shift;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output start, base_addr, in_valid, in_cond, in_opcode, in_Rn, in_Rm, in_Rd,
           in_imm, in_shift_type, in_shift_amt, in_use_shift, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, count, overflow
  );

  modport slave (
    input  start, base_addr, in_valid, in_cond, in_opcode, in_Rn, in_Rm, in_Rd,
           in_imm, in_shift_type, in_shift_amt, in_use_shift, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, count, overflow
  );
endinterface

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader
//   Packs instruction fields into 32-bit Unified Instruction Format words
//   cond[31:28] opcode[27:23] Rn[22:19] Rm[18:15] Rd[14:11] imm[10:0]
//   and streams them into instruction memory, one word per accepted beat,
//   starting at a per-session base address.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : instruction_encoder_loader_if.slave
//          start/base_addr  open or restart a session
//          in_valid/in_ready field-beat handshake, in_last closes the session
//          mem_we/mem_addr/mem_wdata  registered memory write (1 cycle after accept)
//          busy/done/count/overflow   session status
// Parameters
//   ADDR_W    : word-address width
//   MAX_WORDS : words accepted per session before forced close (1..2**ADDR_W)
// Configuration macro
//   ENC_SHIFT_MERGE_EN : when defined, in_use_shift=1 packs
//                        {in_shift_type, in_shift_amt, in_imm[3:0]} into imm.
module instruction_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  instruction_encoder_loader_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);

  state_t            state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              accept_p0;
  logic              cap_hit_p0;
  logic              mem_we_p1;
  logic [ADDR_W-1:0] mem_addr_p1;
  logic [31:0]       mem_wdata_p1;

  function automatic logic [10:0] merge_imm(
    input logic [10:0] imm,
    input logic [1:0]  shift_type,
    input logic [4:0]  shift_amt,
    input logic        use_shift
  );
`ifdef ENC_SHIFT_MERGE_EN
    return use_shift ? {shift_type, shift_amt, imm[3:0]} : imm;
`else
    return imm;
`endif
  endfunction

  function automatic logic [31:0] encode_word(
    input logic [3:0]  cond,
    input logic [4:0]  opcode,
    input logic [3:0]  rn,
    input logic [3:0]  rm,
    input logic [3:0]  rd,
    input logic [10:0] imm
  );
    return {cond, opcode, rn, rm, rd, imm};
  endfunction

`ifndef ENC_SHIFT_MERGE_EN
  // Shift fields have no effect in this build; folded here so they are not dangling.
  logic unused_shift_fields;
  assign unused_shift_fields = ^{bus.in_shift_type, bus.in_shift_amt, bus.in_use_shift};
`endif

  // ---- stage p0: handshake and session control ----
  // A start pulse owns its cycle: no beat is taken while the session restarts.
  assign bus.in_ready = (state == LOAD) & ~bus.start;
  assign accept_p0    = bus.in_valid & bus.in_ready;
  assign cap_hit_p0   = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      base_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      mem_we_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
    end else begin
      mem_we_p1 <= accept_p0;

      // ---- stage p1: registered encode and memory write ----
      if (accept_p0) begin
        mem_addr_p1  <= base_q + idx[ADDR_W-1:0];
        mem_wdata_p1 <= encode_word(bus.in_cond, bus.in_opcode, bus.in_Rn, bus.in_Rm,
                                    bus.in_Rd,
                                    merge_imm(bus.in_imm, bus.in_shift_type,
                                              bus.in_shift_amt, bus.in_use_shift));
        idx     <= idx + 1'b1;
        count_q <= count_q + 1'b1;
        if (cap_hit_p0 && !bus.in_last) overflow_q <= 1'b1;
      end

      case (state)
        IDLE: if (bus.start) state <= LOAD;
        LOAD: begin
          if (!bus.start && accept_p0 && (bus.in_last || cap_hit_p0)) state <= DONE;
        end
        DONE: state <= bus.start ? LOAD : IDLE;
        default: state <= IDLE;
      endcase

      // Restart wins over the accept bookkeeping above (accept is already
      // blocked by in_ready while start is high); an in-flight write still
      // drains at its old address because mem_*_p1 are left alone.
      if (bus.start) begin
        idx        <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
        base_q     <= bus.base_addr;
      end
    end
  end

  assign bus.mem_we    = mem_we_p1;
  assign bus.mem_addr  = mem_addr_p1;
  assign bus.mem_wdata = mem_wdata_p1;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
module tb_instruction_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int MAXW   = 4;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_encoder_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  instruction_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] exp_base;
  int         exp_idx;

  function automatic logic [31:0] enc(input logic [3:0] c, input logic [4:0] op,
                                      input logic [3:0] rn, input logic [3:0] rm,
                                      input logic [3:0] rd, input logic [10:0] imm);
    return {c, op, rn, rm, rd, imm};
  endfunction

  // Scoreboard: every memory write must match the oldest outstanding accept.
  always @(negedge clk) begin
    if (ifc.mem_we === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_write: mem_we=1 addr=%h data=%h, required no write", ifc.mem_addr, ifc.mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (ifc.mem_addr !== mon_e.addr) begin
          n_err++;
          $display("FAIL write_addr: got %h required %h", ifc.mem_addr, mon_e.addr);
        end
        n_cmp++;
        if (ifc.mem_wdata !== mon_e.data) begin
          n_err++;
          $display("FAIL write_data: got %h required %h", ifc.mem_wdata, mon_e.data);
        end
        n_cmp++;
        if (ifc.done !== mon_e.done) begin
          n_err++;
          $display("FAIL write_done: got %b required %b", ifc.done, mon_e.done);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ifc.start = 1'b0;  ifc.base_addr = '0;  ifc.in_valid = 1'b0;
    ifc.in_cond = '0;  ifc.in_opcode = '0;  ifc.in_Rn = '0;  ifc.in_Rm = '0;
    ifc.in_Rd = '0;    ifc.in_imm = '0;     ifc.in_shift_type = '0;
    ifc.in_shift_amt = '0;  ifc.in_use_shift = 1'b0;  ifc.in_last = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the start cycle.
  task automatic do_start(input logic [7:0] b);
    ifc.start = 1'b1;
    ifc.base_addr = b;
    @(negedge clk);
    ifc.start = 1'b0;
    exp_base = b;
    exp_idx = 0;
  endtask

  // Called at a negedge; holds the beat until accepted, pushes the expectation,
  // returns at the negedge where its write is visible.
  task automatic send_beat(input logic [3:0] c, input logic [4:0] op, input logic [3:0] rn,
                           input logic [3:0] rm, input logic [3:0] rd, input logic [10:0] imm,
                           input logic [1:0] st, input logic [4:0] sa, input logic us,
                           input logic last, input logic [31:0] expw);
    int   waits;
    exp_t e;
    waits = 0;
    ifc.in_cond = c;  ifc.in_opcode = op;  ifc.in_Rn = rn;  ifc.in_Rm = rm;  ifc.in_Rd = rd;
    ifc.in_imm = imm;  ifc.in_shift_type = st;  ifc.in_shift_amt = sa;
    ifc.in_use_shift = us;  ifc.in_last = last;  ifc.in_valid = 1'b1;
    #1;
    while (ifc.in_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    n_cmp++;
    if (ifc.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL beat_accept: in_ready=%b, required 1 within 20 cycles", ifc.in_ready);
      ifc.in_valid = 1'b0;
      @(negedge clk);
      return;
    end
    e.addr = exp_base + 8'(exp_idx);
    e.data = expw;
    e.done = last || (exp_idx == MAXW - 1);
    sb.push_back(e);
    exp_idx++;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", ifc.in_ready); end
    n_cmp++; if (ifc.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b required 0", ifc.mem_we); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", ifc.busy); end
    n_cmp++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", ifc.done); end
    n_cmp++; if (ifc.count !== 9'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", ifc.count); end
    n_cmp++; if (ifc.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b required 0", ifc.overflow); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL idle_in_ready: got %b required 0", ifc.in_ready); end
  endtask

  task automatic test_basic();
    do_start(8'h10);
    n_cmp++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b required 1", ifc.busy); end
    for (int i = 0; i < 3; i++)
      send_beat(4'hE, 5'h01, 4'h1, 4'h2, 4'h3, 11'h005, 2'd0, 5'd0, 1'b0, i == 2, 32'hE0891805);
    @(negedge clk);
    n_cmp++; if (ifc.count !== 9'd3) begin n_err++; $display("FAIL basic_count: got %0d required 3", ifc.count); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy=%b required 0", ifc.busy); end
    n_cmp++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: done=%b required 0", ifc.done); end
  endtask

  task automatic test_gapped();
    do_start(8'h40);
    for (int i = 0; i < 4; i++) begin
      send_beat(4'(i), 5'(i + 3), 4'(i + 4), 4'(i + 5), 4'(i + 6), 11'(16'h100 + i),
                2'd1, 5'd7, 1'b0, i == 3,
                enc(4'(i), 5'(i + 3), 4'(i + 4), 4'(i + 5), 4'(i + 6), 11'(16'h100 + i)));
      @(negedge clk);
    end
    n_cmp++; if (ifc.count !== 9'd4) begin n_err++; $display("FAIL gapped_count: got %0d required 4", ifc.count); end
    n_cmp++; if (ifc.overflow !== 1'b0) begin n_err++; $display("FAIL gapped_overflow: got %b required 0", ifc.overflow); end
  endtask

  task automatic test_wrap();
    do_start(8'hFE);
    for (int i = 0; i < 3; i++)
      send_beat(4'h9, 5'h1F, 4'hA, 4'hB, 4'hC, 11'h7F0 + 11'(i), 2'd0, 5'd0, 1'b0, i == 2,
                enc(4'h9, 5'h1F, 4'hA, 4'hB, 4'hC, 11'h7F0 + 11'(i)));
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_start(8'h20);
    for (int i = 0; i < 4; i++)
      send_beat(4'h5, 5'h0A, 4'(i), 4'h0, 4'hF, 11'h2AA, 2'd0, 5'd0, 1'b0, 1'b0,
                enc(4'h5, 5'h0A, 4'(i), 4'h0, 4'hF, 11'h2AA));
    ifc.in_valid = 1'b1;
    #1;
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_in_ready: got %b required 0", ifc.in_ready); end
    n_cmp++; if (ifc.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b required 1", ifc.overflow); end
    n_cmp++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL ovf_done: got %b required 1", ifc.done); end
    @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_in_ready_idle: got %b required 0", ifc.in_ready); end
    n_cmp++; if (ifc.count !== 9'd4) begin n_err++; $display("FAIL ovf_count: got %0d required 4", ifc.count); end
    n_cmp++; if (ifc.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b required 1", ifc.overflow); end
    ifc.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    do_start(8'h30);
    n_cmp++; if (ifc.overflow !== 1'b0) begin n_err++; $display("FAIL abort_ovf_clear: got %b required 0", ifc.overflow); end
    for (int i = 0; i < 2; i++)
      send_beat(4'h1, 5'h02, 4'h3, 4'h4, 4'h5, 11'h011 + 11'(i), 2'd0, 5'd0, 1'b0, 1'b0,
                enc(4'h1, 5'h02, 4'h3, 4'h4, 4'h5, 11'h011 + 11'(i)));
    ifc.start = 1'b1;
    ifc.base_addr = 8'h50;
    ifc.in_valid = 1'b1;
    ifc.in_cond = 4'h7;  ifc.in_opcode = 5'h15;  ifc.in_imm = 11'h3C3;
    #1;
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b required 0", ifc.in_ready); end
    @(negedge clk);
    ifc.start = 1'b0;
    exp_base = 8'h50;
    exp_idx = 0;
    n_cmp++; if (ifc.count !== 9'd0) begin n_err++; $display("FAIL abort_count: got %0d required 0", ifc.count); end
    send_beat(4'h7, 5'h15, 4'h3, 4'h4, 4'h5, 11'h3C3, 2'd0, 5'd0, 1'b0, 1'b1,
              enc(4'h7, 5'h15, 4'h3, 4'h4, 4'h5, 11'h3C3));
    @(negedge clk);
    n_cmp++; if (ifc.count !== 9'd1) begin n_err++; $display("FAIL abort_new_count: got %0d required 1", ifc.count); end
  endtask

  task automatic test_reset_mid();
    do_start(8'h60);
    ifc.in_valid = 1'b1;
    ifc.in_cond = 4'h2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    n_cmp++; if (ifc.mem_we !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_we: got %b required 0", ifc.mem_we); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b required 0", ifc.busy); end
    @(negedge clk);
    n_cmp++; if (ifc.mem_we !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_we2: got %b required 0", ifc.mem_we); end
  endtask

  task automatic test_shift();
    logic [10:0] merged;
`ifdef ENC_SHIFT_MERGE_EN
    merged = 11'h43F;
`else
    merged = 11'h7FF;
`endif
    do_start(8'h70);
    send_beat(4'hC, 5'h08, 4'h6, 4'h7, 4'h8, 11'h7FF, 2'd2, 5'd3, 1'b1, 1'b0,
              enc(4'hC, 5'h08, 4'h6, 4'h7, 4'h8, merged));
    send_beat(4'hC, 5'h08, 4'h6, 4'h7, 4'h8, 11'h5A5, 2'd2, 5'd3, 1'b0, 1'b1,
              enc(4'hC, 5'h08, 4'h6, 4'h7, 4'h8, 11'h5A5));
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_wrap();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_shift();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
